// File: rtl/calc_ddr3_addr_pipe.sv
// ---------------------------------------------------------------------------
// calc_ddr3_addr_pipe
//
// Pipelined pixel-block address generator. It pops {x, y} block coordinates
// from an upstream FIFO and pushes one DDR3 word address per block into a
// downstream FIFO:
//
//     addr = base[sel_idx] + y*ROW_STRIDE + (x << BLK_WORDS_LOG2)
//
// The result wraps modulo 2^ADDR_W. At full rate the block produces one
// address per clock.
//
// Compile-time option:
//   OOB_DROP_EN  When defined, the block still pops out-of-frame coordinates
//                (x >= FRAME_X or y >= FRAME_Y) but does not push them
//                downstream, and counts them in oob_cnt (saturating at
//                0xFFFF). When undefined, no compare logic is built and
//                oob_cnt is tied to 0.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   coord_data        {x, y}, with x in the upper half. Valid the cycle after
//                     a pop.
//   coord_empty       upstream FIFO empty flag
//   coord_rd_req      upstream pop (registered)
//   frame_base_addr   packed frame bases; buffer i is at [i*BASE_W +: BASE_W]
//   base_addr_index   buffer select, latched on frame_start
//   frame_start       one-cycle frame pulse
//   addr_afull        downstream FIFO has fewer than 4 free entries
//   ddr3_addr         computed address; holds when wr_fifo_en is low
//   wr_fifo_en        downstream push
//   oob_cnt           number of rejected coordinates
//   busy              any pipeline stage holds a valid entry
//
// Pipeline (coord_rd_req high in cycle t):
//   t   : pop is issued. On the pop edge, vld[1] is set and the selected
//         base is registered.
//   t+1 : S1. The FIFO output register holds x/y. S2 registers prod and off.
//   t+2 : S2 -> S3. The sum is registered.
//   t+3 : ddr3_addr and wr_fifo_en are valid.
// ---------------------------------------------------------------------------
module calc_ddr3_addr_pipe #(
    parameter int FRAME_X        = 1920,
    parameter int FRAME_Y        = 1080,
    parameter int ROW_STRIDE     = 1920,
    parameter int COORD_W        = 11,
    parameter int BLK_WORDS_LOG2 = 2,
    parameter int BASE_W         = 24,
    parameter int ADDR_W         = 26,
    parameter int NUM_BUF        = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2*COORD_W-1:0]         coord_data,
    input  logic                         coord_empty,
    output logic                         coord_rd_req,
    input  logic [NUM_BUF*BASE_W-1:0]    frame_base_addr,
    input  logic [$clog2(NUM_BUF)-1:0]   base_addr_index,
    input  logic                         frame_start,
    input  logic                         addr_afull,
    output logic [ADDR_W-1:0]            ddr3_addr,
    output logic                         wr_fifo_en,
    output logic [15:0]                  oob_cnt,
    output logic                         busy
);

    localparam int IDX_W    = $clog2(NUM_BUF);
    localparam int STRIDE_W = $clog2(ROW_STRIDE + 1);
    localparam int PROD_W   = COORD_W + STRIDE_W;
    localparam int SHX_W    = COORD_W + BLK_WORDS_LOG2;
    // One carry bit above the wider of base and shifted x.
    localparam int OFF_W    = ((BASE_W > SHX_W) ? BASE_W : SHX_W) + 1;

    // Elaboration-time sanity checks on the configuration.
    if (NUM_BUF < 2) begin : g_bad_nbuf
        $error("calc_ddr3_addr_pipe: NUM_BUF must be at least 2");
    end
    if ((FRAME_X > (1 << COORD_W)) || (FRAME_Y > (1 << COORD_W))) begin : g_bad_frame
        $error("calc_ddr3_addr_pipe: frame limits exceed coordinate range");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                rd_req_q,  rd_req_d;
    logic [3:1]          vld_pipe_q, vld_pipe_d;
    logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
    logic [BASE_W-1:0]   base_q,    base_d;
    logic [PROD_W-1:0]   prod_q,    prod_d;
    logic [OFF_W-1:0]    off_q,     off_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                wr_q,      wr_d;

    logic [COORD_W-1:0]  x_s1, y_s1;
    logic                pop_ok;

    assign x_s1 = coord_data[2*COORD_W-1:COORD_W];
    assign y_s1 = coord_data[COORD_W-1:0];

    // A pop counts only if the FIFO really holds data on that edge. Because
    // the request is registered, it can stay high for one cycle after the
    // FIFO drains; that trailing request is ignored here.
    assign pop_ok = rd_req_q && !coord_empty;

    // -----------------------------------------------------------------------
    // Frame base select. An index outside 0..NUM_BUF-1 falls back to
    // buffer 0.
    // -----------------------------------------------------------------------
    logic [BASE_W-1:0] base_sel;

    always_comb begin
        base_sel = frame_base_addr[0 +: BASE_W];
        for (int i = 1; i < NUM_BUF; i++) begin
            if (sel_idx_q == IDX_W'(i)) begin
                base_sel = frame_base_addr[i*BASE_W +: BASE_W];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Optional out-of-frame rejection
    // -----------------------------------------------------------------------
`ifdef OOB_DROP_EN
    logic        oob_s1;
    logic        oob2_q, oob2_d;
    logic [15:0] oob_cnt_q, oob_cnt_d;

    assign oob_s1 = (32'(x_s1) >= FRAME_X) || (32'(y_s1) >= FRAME_Y);

    always_comb begin
        oob2_d    = oob2_q;
        oob_cnt_d = oob_cnt_q;
        if (vld_pipe_q[1]) begin
            oob2_d = oob_s1;
        end
        if (vld_pipe_q[2] && oob2_q && (oob_cnt_q != 16'hFFFF)) begin
            oob_cnt_d = oob_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob2_q    <= 1'b0;
            oob_cnt_q <= '0;
        end else begin
            oob2_q    <= oob2_d;
            oob_cnt_q <= oob_cnt_d;
        end
    end

    assign wr_d    = vld_pipe_q[2] && !oob2_q;
    assign oob_cnt = oob_cnt_q;
`else
    assign wr_d    = vld_pipe_q[2];
    assign oob_cnt = '0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // The registered request needs no knowledge of FIFO depth. At most
        // 3 entries are in flight, and the 4-entry afull margin absorbs them.
        rd_req_d   = !coord_empty && !addr_afull;
        vld_pipe_d = {vld_pipe_q[2], vld_pipe_q[1], pop_ok};

        // frame_start updates the select on this edge. An entry popped on
        // the same edge still registers the old base below.
        sel_idx_d  = frame_start ? base_addr_index : sel_idx_q;

        base_d     = base_q;
        prod_d     = prod_q;
        off_d      = off_q;
        addr_d     = addr_q;

        if (pop_ok) begin
            base_d = base_sel;
        end
        if (vld_pipe_q[1]) begin
            prod_d = PROD_W'(y_s1) * PROD_W'(ROW_STRIDE);
            off_d  = OFF_W'(base_q) + (OFF_W'(x_s1) << BLK_WORDS_LOG2);
        end
        // The address updates only on a push, so it holds between pushes.
        if (wr_d) begin
            addr_d = ADDR_W'(prod_q) + ADDR_W'(off_q);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_q   <= 1'b0;
            vld_pipe_q <= '0;
            sel_idx_q  <= '0;
            base_q     <= '0;
            prod_q     <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            rd_req_q   <= rd_req_d;
            vld_pipe_q <= vld_pipe_d;
            sel_idx_q  <= sel_idx_d;
            base_q     <= base_d;
            prod_q     <= prod_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
        end
    end

    assign coord_rd_req = rd_req_q;
    assign ddr3_addr    = addr_q;
    assign wr_fifo_en   = wr_q;
    assign busy         = |vld_pipe_q;

endmodule

// File: tb/tb_calc_ddr3_addr_pipe.sv
// Directed testbench for calc_ddr3_addr_pipe. The upstream coordinate FIFO
// is modelled as a small array with read/write pointers; expected addresses
// are hand-computed constants.
module tb_calc_ddr3_addr_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [21:0] coord_data = '0;
    logic        coord_empty;
    logic        coord_rd_req;
    logic [95:0] frame_base_addr;
    logic [1:0]  base_addr_index;
    logic        frame_start;
    logic        addr_afull;
    logic [25:0] ddr3_addr;
    logic        wr_fifo_en;
    logic [15:0] oob_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    calc_ddr3_addr_pipe dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .coord_data      (coord_data),
        .coord_empty     (coord_empty),
        .coord_rd_req    (coord_rd_req),
        .frame_base_addr (frame_base_addr),
        .base_addr_index (base_addr_index),
        .frame_start     (frame_start),
        .addr_afull      (addr_afull),
        .ddr3_addr       (ddr3_addr),
        .wr_fifo_en      (wr_fifo_en),
        .oob_cnt         (oob_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model. Data appears the cycle after a pop.
    logic [21:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign coord_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (coord_rd_req && !coord_empty) begin
            coord_data <= fifo_mem[rd_ptr[5:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic push(input int x, input int y);
        logic [10:0] xs, ys;
        xs = x[10:0];
        ys = y[10:0];
        fifo_mem[wr_ptr[5:0]] = {xs, ys};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (coord_rd_req !== 1'b0) $display("FAIL reset_rd_req got %b exp 0", coord_rd_req);
        checks++; if (wr_fifo_en !== 1'b0)   $display("FAIL reset_wr_en got %b exp 0", wr_fifo_en);
        checks++; if (ddr3_addr !== 26'h0)   $display("FAIL reset_addr got %h exp 0", ddr3_addr);
        checks++; if (oob_cnt !== 16'h0)     $display("FAIL reset_oob_cnt got %h exp 0", oob_cnt);
        checks++; if (busy !== 1'b0)         $display("FAIL reset_busy got %b exp 0", busy);
        errors += (coord_rd_req !== 1'b0) + (wr_fifo_en !== 1'b0) + (ddr3_addr !== 26'h0)
                + (oob_cnt !== 16'h0) + (busy !== 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (coord_rd_req !== 1'b0) begin
            errors++; $display("FAIL idle_empty_rd_req got %b exp 0", coord_rd_req);
        end
    endtask

    task automatic test_single();
        int t_req, t_wr, n;
        logic [25:0] got;
        t_req = -1; t_wr = -1; n = 0; got = '0;
        push(5, 2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (coord_rd_req && t_req < 0) t_req = k;
            if (wr_fifo_en) begin n++; t_wr = k; got = ddr3_addr; end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", n); end
        checks++; if (t_wr - t_req !== 3) begin errors++; $display("FAIL single_latency got %0d exp 3", t_wr - t_req); end
        checks++; if (got !== 26'h001014) begin errors++; $display("FAIL single_addr got %h exp 001014", got); end
        checks++; if (ddr3_addr !== 26'h001014) begin errors++; $display("FAIL single_hold got %h exp 001014", ddr3_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_burst();
        int n, first, last;
        logic [25:0] exp;
        n = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) push(i, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (wr_fifo_en) begin
                exp = 26'h100 + 26'(4 * n);
                checks++;
                if (ddr3_addr !== exp) begin errors++; $display("FAIL burst_addr%0d got %h exp %h", n, ddr3_addr, exp); end
                if (first < 0) first = k;
                last = k;
                n++;
            end
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL burst_count got %0d exp 8", n); end
        checks++; if (last - first !== 7) begin errors++; $display("FAIL burst_span got %0d exp 7", last - first); end
    endtask

    task automatic test_back_to_back();
        int npush, n_hold;
        logic [25:0] exp;
        npush = 0; n_hold = 0;
        for (int i = 0; i < 12; i++) push(i, 1);
        for (int k = 0; k < 60 && npush < 12; k++) begin
            @(negedge clk);
            if (k >= 5 && k <= 12) begin
                checks++;
                if (coord_rd_req !== 1'b0) begin errors++; $display("FAIL bp_rd_req_k%0d got %b exp 0", k, coord_rd_req); end
            end
            if (wr_fifo_en) begin
                exp = 26'h880 + 26'(4 * npush);
                checks++;
                if (ddr3_addr !== exp) begin errors++; $display("FAIL bp_addr%0d got %h exp %h", npush, ddr3_addr, exp); end
                npush++;
                if (k >= 5 && k <= 12) n_hold++;
            end
            if (k == 4)  addr_afull = 1'b1;
            if (k == 12) addr_afull = 1'b0;
        end
        addr_afull = 1'b0;
        checks++; if (npush !== 12) begin errors++; $display("FAIL bp_count got %0d exp 12", npush); end
        checks++; if (n_hold > 3) begin errors++; $display("FAIL bp_drain got %0d exp <=3", n_hold); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (wr_fifo_en !== 1'b0) begin errors++; $display("FAIL bp_extra_push got %b exp 0", wr_fifo_en); end
        end
    endtask

    task automatic test_buf_switch();
        logic [25:0] got [0:1];
        int n;
        // Entry before the switch uses buffer 0.
        n = 0; got[0] = '0; got[1] = '0;
        push(0, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wr_fifo_en && n < 2) begin got[n] = ddr3_addr; n++; end
        end
        frame_start = 1'b1; base_addr_index = 2'd2;
        @(negedge clk);
        frame_start = 1'b0;
        push(0, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wr_fifo_en && n < 2) begin got[n] = ddr3_addr; n++; end
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL sw_count got %0d exp 2", n); end
        checks++; if (got[0] !== 26'h000100) begin errors++; $display("FAIL sw_old_base got %h exp 000100", got[0]); end
        checks++; if (got[1] !== 26'h200000) begin errors++; $display("FAIL sw_new_base got %h exp 200000", got[1]); end

        // frame_start coincides with the pop of A: A keeps the old base (2),
        // and B (popped a cycle later) takes the new base (3).
        n = 0; got[0] = '0; got[1] = '0;
        push(0, 0);
        push(1, 0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (coord_rd_req !== 1'b1) begin errors++; $display("FAIL sw_align_rd_req got %b exp 1", coord_rd_req); end
                frame_start = 1'b1; base_addr_index = 2'd3;
            end
            if (k == 1) frame_start = 1'b0;
            if (wr_fifo_en && n < 2) begin got[n] = ddr3_addr; n++; end
        end
        checks++; if (got[0] !== 26'h200000) begin errors++; $display("FAIL sw_same_cycle got %h exp 200000", got[0]); end
        checks++; if (got[1] !== 26'h300004) begin errors++; $display("FAIL sw_next_cycle got %h exp 300004", got[1]); end
        frame_start = 1'b1; base_addr_index = 2'd0;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_oob();
        logic [25:0] exp_q [$];
        int n;
        logic [15:0] exp_cnt;
`ifdef OOB_DROP_EN
        exp_q = '{26'h000884};
        exp_cnt = 16'd2;
`else
        exp_q = '{26'h001F00, 26'h1FA500, 26'h000884};
        exp_cnt = 16'd0;
`endif
        n = 0;
        push(1920, 0);
        push(0, 1080);
        push(1, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_fifo_en) begin
                checks++;
                if (n >= exp_q.size()) begin
                    errors++; $display("FAIL oob_unexpected_push got %h", ddr3_addr);
                end else if (ddr3_addr !== exp_q[n]) begin
                    errors++; $display("FAIL oob_addr%0d got %h exp %h", n, ddr3_addr, exp_q[n]);
                end
                n++;
            end
        end
        checks++; if (n !== exp_q.size()) begin errors++; $display("FAIL oob_count got %0d exp %0d", n, exp_q.size()); end
        checks++; if (oob_cnt !== exp_cnt) begin errors++; $display("FAIL oob_cnt got %0d exp %0d", oob_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        int n, t_req, t_wr;
        logic [25:0] got;
        for (int i = 0; i < 6; i++) push(i, 3);
        for (int k = 0; k < 3; k++) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (coord_rd_req !== 1'b0) begin errors++; $display("FAIL mid_rd_req got %b exp 0", coord_rd_req); end
        checks++; if (wr_fifo_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en got %b exp 0", wr_fifo_en); end
        checks++; if (ddr3_addr !== 26'h0) begin errors++; $display("FAIL mid_addr got %h exp 0", ddr3_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (oob_cnt !== 16'h0) begin errors++; $display("FAIL mid_oob_cnt got %h exp 0", oob_cnt); end
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wr_fifo_en) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL mid_push_in_reset got %0d exp 0", n); end
        wr_ptr = rd_ptr;
        rst_n = 1'b1;
        @(negedge clk);
        push(2, 0);
        n = 0; t_req = -1; t_wr = -1; got = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (coord_rd_req && t_req < 0) t_req = k;
            if (wr_fifo_en) begin n++; t_wr = k; got = ddr3_addr; end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL mid_restart_count got %0d exp 1", n); end
        checks++; if (got !== 26'h000108) begin errors++; $display("FAIL mid_restart_addr got %h exp 000108", got); end
        checks++; if (t_wr - t_req !== 3) begin errors++; $display("FAIL mid_restart_latency got %0d exp 3", t_wr - t_req); end
    endtask

    initial begin
        frame_base_addr = {24'h300000, 24'h200000, 24'h080000, 24'h000100};
        base_addr_index = 2'd0;
        frame_start     = 1'b0;
        addr_afull      = 1'b0;
        rst_n           = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_buf_switch();
        test_oob();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
